// File: rtl/serial_mem_loader.sv
// Serial boot loader: parses a framed load command from the UART byte stream,
// writes full words into instruction/data RAM while pausing the core, and replies ACK/NAK.
module serial_mem_loader #(
    parameter int          TIMEOUT  = 1000000,
    parameter logic [7:0]  ACK_BYTE = 8'h06,
    parameter logic [7:0]  NAK_BYTE = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        pause_o,
    output logic [31:0] addr_o,
    output logic [31:0] dout_o,
    output logic [3:0]  wr_en_o,
    output logic        load_ok_o,
    output logic        load_err_o
);

    typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, CSUM, ACK} state_t;

    localparam logic [7:0]  SYNC     = 8'h55;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] word_cnt;
    logic [31:0] cur_addr;
    logic [23:0] word_sh;
    logic [7:0]  sum;
    logic [31:0] tmo_cnt;

    logic in_frame;
    assign in_frame = (state == ADDR) || (state == CNT) || (state == DATA) || (state == CSUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word_cnt   <= '0;
            cur_addr   <= '0;
            word_sh    <= '0;
            sum        <= '0;
            tmo_cnt    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            pause_o    <= 1'b0;
            addr_o     <= '0;
            dout_o     <= '0;
            wr_en_o    <= '0;
            load_ok_o  <= 1'b0;
            load_err_o <= 1'b0;
        end else begin
            wr_en_o    <= '0;
            load_ok_o  <= 1'b0;
            load_err_o <= 1'b0;

            // A byte arriving on the expiry cycle keeps the frame alive.
            if (in_frame && !rx_valid && tmo_cnt == TMO_LAST) begin
                state      <= IDLE;
                pause_o    <= 1'b0;
                load_err_o <= 1'b1;
                tmo_cnt    <= '0;
                byte_idx   <= '0;
            end else begin
                if (rx_valid || !in_frame)
                    tmo_cnt <= '0;
                else
                    tmo_cnt <= tmo_cnt + 32'd1;

                case (state)
                    IDLE: begin
                        if (rx_valid && rx_data == SYNC) begin
                            state    <= ADDR;
                            pause_o  <= 1'b1;
                            byte_idx <= '0;
                            sum      <= '0;
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            cur_addr <= {cur_addr[23:0], rx_data};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3)
                                state <= CNT;
                        end
                    end
                    CNT: begin
                        if (rx_valid) begin
                            word_cnt <= {word_cnt[7:0], rx_data};
                            if (byte_idx[0]) begin
                                byte_idx <= '0;
                                state    <= ({word_cnt[7:0], rx_data} == 16'd0) ? CSUM : DATA;
                            end else begin
                                byte_idx <= 2'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            word_sh  <= {word_sh[15:0], rx_data};
                            sum      <= sum + rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                // Low address bits are dropped here so the
                                // running address stays a plain counter.
                                wr_en_o  <= 4'b1111;
                                addr_o   <= {cur_addr[31:2], 2'b00};
                                dout_o   <= {word_sh, rx_data};
                                cur_addr <= cur_addr + 32'd4;
                                word_cnt <= word_cnt - 16'd1;
                                if (word_cnt == 16'd1)
                                    state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_valid) begin
                            tx_valid <= 1'b1;
                            state    <= ACK;
                            if (rx_data == sum) begin
                                tx_data   <= ACK_BYTE;
                                load_ok_o <= 1'b1;
                            end else begin
                                tx_data    <= NAK_BYTE;
                                load_err_o <= 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            pause_o  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
